// File: rtl/adder_mw_seq.sv
// -----------------------------------------------------------------------------
// adder_mw_seq
//
// Multi-word add/subtract sequencer. It owns the shared 16-bit adder and
// chains it over 1..2^CNT_W-1 words, least-significant word first. Carry or
// borrow is carried between words internally. Operand pairs stream in and
// result words stream out over valid/ready handshakes.
//
// Subtraction uses A - B - borrow = A + ~B + ~borrow. The internal carry
// register therefore holds "not borrow" during a subtract, and it is flipped
// back when the final carry_out is reported.
//
// Optional feature macro: ADDER_MW_SEQ_OVF_EN
//   defined   -> ovf reports signed overflow of the whole multi-word result
//   undefined -> ovf is tied to 0 and no overflow logic is built
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   begin transaction (sampled only while idle)
//   sub         in   0 = add, 1 = subtract (latched at accepted start)
//   num_words   in   transaction length in words (latched at accepted start)
//   cy_init     in   initial carry (add) / borrow (sub)
//   op_valid    in   operand pair valid
//   op_ready    out  operand pair accepted when op_valid && op_ready
//   op_a        in   augend / minuend word
//   op_b        in   addend / subtrahend word
//   add_a       out  to adder A
//   add_b       out  to adder B
//   add_cy_in   out  to adder CY_In
//   add_out     in   from adder sum (combinational)
//   add_cy_out  in   from adder CY_Out (combinational)
//   res_valid   out  result word valid
//   res_ready   in   consumer ready
//   res_word    out  result word
//   res_last    out  final word marker, qualified by res_valid
//   busy        out  sequencer not idle
//   done        out  one-cycle pulse at transaction end
//   carry_out   out  final carry (add) / borrow (sub), held until next start
//   ovf         out  signed overflow of the whole result (optional feature)
// -----------------------------------------------------------------------------
module adder_mw_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [CNT_W-1:0] num_words,
  input  logic             cy_init,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cy_in,
  input  logic [15:0]      add_out,
  input  logic             add_cy_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_word,
  output logic             res_last,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic             sub_q;
  logic [CNT_W-1:0] remaining;
  logic             carry_q;

  logic [15:0]      b_eff;
  logic             accept;
  logic             start_accept;
  logic             last_accept;
  logic             out_handshake;
  logic             finish;

  // B is inverted for subtraction so the same adder computes A + ~B + ~borrow.
  assign b_eff = sub_q ? ~op_b : op_b;

  // A single output register with no skid buffer: a new operand may be taken
  // only when that register is empty or being emptied this same cycle.
  assign op_ready      = (state == RUN) && (!res_valid || res_ready);
  assign accept        = op_valid && op_ready;
  assign start_accept  = (state == IDLE) && start && (num_words != '0);
  assign last_accept   = accept && (remaining == CNT_W'(1));
  assign out_handshake = res_valid && res_ready;
  assign finish        = (state == DRAIN) && out_handshake && res_last;

  assign busy = (state != IDLE);

  // The adder is only driven while words are flowing; otherwise it sees
  // zeros so the shared instance is quiet for other users.
  always_comb begin
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_cy_in = 1'b0;
    if (state == RUN) begin
      add_a     = op_a;
      add_b     = b_eff;
      add_cy_in = carry_q;
    end
  end

  // Main sequencer: state, latched mode, word counter, carry chain, the
  // output register and the end-of-transaction reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sub_q     <= 1'b0;
      remaining <= '0;
      carry_q   <= 1'b0;
      res_valid <= 1'b0;
      res_word  <= 16'h0000;
      res_last  <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_accept) begin
            state     <= RUN;
            sub_q     <= sub;
            remaining <= num_words;
            carry_q   <= sub ? ~cy_init : cy_init;
            carry_out <= 1'b0;
          end
        end

        RUN: begin
          if (accept) begin
            res_word  <= add_out;
            res_valid <= 1'b1;
            res_last  <= last_accept;
            carry_q   <= add_cy_out;
            remaining <= remaining - CNT_W'(1);
            if (last_accept) begin
              state <= DRAIN;
            end
          end else if (out_handshake) begin
            res_valid <= 1'b0;
          end
        end

        DRAIN: begin
          if (out_handshake) begin
            res_valid <= 1'b0;
            if (res_last) begin
              res_last  <= 1'b0;
              done      <= 1'b1;
              carry_out <= sub_q ? ~carry_q : carry_q;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_MW_SEQ_OVF_EN
  logic ovf_cap;
  logic ovf_v;

  // Signed overflow is decided by the most significant word only: operands of
  // equal sign producing a sum of the opposite sign.
  assign ovf_v = (op_a[15] == b_eff[15]) && (add_out[15] != op_a[15]);

  // The flag is captured when the final word goes through the adder, but it
  // only becomes visible together with done, and is cleared by a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cap <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (start_accept) begin
        ovf_cap <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        if (last_accept) begin
          ovf_cap <= ovf_v;
        end
        if (finish) begin
          ovf <= ovf_cap;
        end
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_mw_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_mw_seq
//
// Self-checking bench for adder_mw_seq. A behavioural 16-bit adder stands in
// for the shared adder instance. Directed vectors with hand-computed results
// are run from a table, followed by hand-written sequences for backpressure,
// ignored starts and reset during a transaction.
// -----------------------------------------------------------------------------
module tb_adder_mw_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sub;
  logic [3:0]  num_words;
  logic        cy_init;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cy_in;
  logic [15:0] add_out;
  logic        add_cy_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_word;
  logic        res_last;
  logic        busy;
  logic        done;
  logic        carry_out;
  logic        ovf;

  int total_count;
  int bad_count;
  int done_count;

  typedef struct {
    logic              sub;
    logic [3:0]        num;
    logic              cy;
    logic [2:0][15:0]  a;
    logic [2:0][15:0]  b;
    logic [2:0][15:0]  res;
    logic              cy_exp;
    logic              ovf_exp;
  } vec_t;

  vec_t vecs[6];

  adder_mw_seq #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sub        (sub),
    .num_words  (num_words),
    .cy_init    (cy_init),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cy_in  (add_cy_in),
    .add_out    (add_out),
    .add_cy_out (add_cy_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_word   (res_word),
    .res_last   (res_last),
    .busy       (busy),
    .done       (done),
    .carry_out  (carry_out),
    .ovf        (ovf)
  );

  // Stand-in for the shared adder: a plain 17-bit sum.
  assign {add_cy_out, add_out} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cy_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge; done lasts one cycle.
  always @(negedge clk) begin
    if (done) done_count++;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic s, input logic [3:0] n, input logic c,
                                 input logic [15:0] a0, input logic [15:0] b0, input logic [15:0] r0,
                                 input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] r1,
                                 input logic [15:0] a2, input logic [15:0] b2, input logic [15:0] r2,
                                 input logic cyx, input logic ovx);
    vec_t v;
    v.sub = s; v.num = n; v.cy = c;
    v.a[0] = a0; v.b[0] = b0; v.res[0] = r0;
    v.a[1] = a1; v.b[1] = b1; v.res[1] = r1;
    v.a[2] = a2; v.b[2] = b2; v.res[2] = r2;
    v.cy_exp = cyx;
`ifdef ADDER_MW_SEQ_OVF_EN
    v.ovf_exp = ovx;
`else
    v.ovf_exp = 1'b0;
    if (ovx) v.ovf_exp = 1'b0;
`endif
    return v;
  endfunction

  // Wait (bounded) until op_ready is high at a negedge.
  task automatic waitReady(input string name);
    int cycles = 0;
    while (!op_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!op_ready) checkOutput({name, " op_ready timeout"}, 32'd0, 32'd1);
  endtask

  // Run one full transaction with res_ready held high and check every word,
  // the end pulse and the final flags.
  task automatic applyStimulus(input vec_t v, input int idx);
    int done_before;
    string tag;
    tag = $sformatf("vec%0d", idx);
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; sub = v.sub; num_words = v.num; cy_init = v.cy;
    @(negedge clk);
    start = 1'b0; sub = 1'b0; cy_init = 1'b0;
    done_before = done_count;
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    for (int w = 0; w < int'(v.num); w++) begin
      op_valid = 1'b1; op_a = v.a[w]; op_b = v.b[w];
      waitReady(tag);
      @(negedge clk);
      op_valid = 1'b0;
      checkOutput($sformatf("%s word%0d", tag, w), 32'(res_word), 32'(v.res[w]));
      checkOutput($sformatf("%s last%0d", tag, w), 32'(res_last), 32'(w == int'(v.num) - 1));
    end
    @(negedge clk);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " carry_out"}, 32'(carry_out), 32'(v.cy_exp));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(v.ovf_exp));
    checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done count"}, 32'(done_count - done_before), 32'd1);
    checkOutput({tag, " carry held"}, 32'(carry_out), 32'(v.cy_exp));
  endtask

  initial begin
    int done_before;
    total_count = 0; bad_count = 0; done_count = 0;
    reset_n = 1'b0; start = 1'b0; sub = 1'b0; num_words = '0; cy_init = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;

    //                 sub  n    cy   a0       b0       r0       a1       b1       r1       a2       b2       r2       cy   ovf
    vecs[0] = mkVec(1'b0, 4'd2, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    vecs[1] = mkVec(1'b1, 4'd1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    vecs[2] = mkVec(1'b0, 4'd1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    vecs[3] = mkVec(1'b1, 4'd2, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    vecs[4] = mkVec(1'b0, 4'd3, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    vecs[5] = mkVec(1'b1, 4'd1, 1'b1, 16'h0010, 16'h0003, 16'h000C, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst op_ready", 32'(op_ready), 32'd0);
    checkOutput("rst res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst res_last", 32'(res_last), 32'd0);
    checkOutput("rst res_word", 32'(res_word), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst carry_out", 32'(carry_out), 32'd0);
    checkOutput("rst ovf", 32'(ovf), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst add_a", 32'(add_a), 32'd0);
    checkOutput("rst add_b", 32'(add_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Backpressure: 3-word add, consumer stalls 3 cycles after the first result
    done_before = done_count;
    res_ready = 1'b0;
    start = 1'b1; sub = 1'b0; num_words = 4'd3; cy_init = 1'b0;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0002;
    waitReady("bp");
    @(negedge clk);
    op_a = 16'h0003; op_b = 16'h0004;
    checkOutput("bp word0", 32'(res_word), 32'h0003);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("bp stall ready%0d", c), 32'(op_ready), 32'd0);
      checkOutput($sformatf("bp stall word%0d", c), 32'(res_word), 32'h0003);
      checkOutput($sformatf("bp stall valid%0d", c), 32'(res_valid), 32'd1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    checkOutput("bp release ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    checkOutput("bp word1", 32'(res_word), 32'h0007);
    op_a = 16'h0005; op_b = 16'h0006;
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("bp word2", 32'(res_word), 32'h000B);
    checkOutput("bp last", 32'(res_last), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp done count", 32'(done_count - done_before), 32'd1);
    checkOutput("bp idle", 32'(busy), 32'd0);

    // start with num_words == 0 is ignored
    done_before = done_count;
    start = 1'b1; num_words = 4'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero no done", 32'(done_count - done_before), 32'd0);

    // start pulsed during RUN is ignored
    done_before = done_count;
    start = 1'b1; sub = 1'b0; num_words = 4'd2; cy_init = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; num_words = 4'd5; cy_init = 1'b1;
    op_valid = 1'b1; op_a = 16'h000A; op_b = 16'h0014;
    @(negedge clk);
    start = 1'b0; sub = 1'b0; cy_init = 1'b0;
    checkOutput("busy-start word0", 32'(res_word), 32'h001E);
    op_a = 16'h001E; op_b = 16'h0028;
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("busy-start word1", 32'(res_word), 32'h0046);
    checkOutput("busy-start last", 32'(res_last), 32'd1);
    @(negedge clk);
    checkOutput("busy-start done", 32'(done), 32'd1);
    checkOutput("busy-start carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    checkOutput("busy-start done count", 32'(done_count - done_before), 32'd1);

    // Reset after one of three words accepted
    done_before = done_count;
    start = 1'b1; sub = 1'b0; num_words = 4'd3; cy_init = 1'b0;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("abort word0", 32'(res_word), 32'h3333);
    reset_n = 1'b0;
    #1;
    checkOutput("abort res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort no done", 32'(done_count - done_before), 32'd0);
    applyStimulus(mkVec(1'b0, 4'd1, 1'b0, 16'h1234, 16'h0001, 16'h1235,
                        16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0), 99);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
